// File: rtl/normalize_for_floating_point32.sv
// -----------------------------------------------------------------------------
// normalize_for_floating_point32
//
// Last stage of the FP32 add/sub pipeline. It takes the signed-magnitude
// mantissa sum/difference from the add/sub stage and the common exponent,
// normalizes it with a leading-zero count and shift, rounds the carry case to
// nearest-even, handles zero, overflow and underflow, and packs an IEEE-754
// single-precision word. Two pipeline stages with a valid bit alongside.
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   valid_in     qualifies sign / exponent / adder_value this cycle
//   sign         result sign from the add/sub stage
//   exponent     biased exponent of the larger operand (post-alignment)
//   adder_value  mantissa magnitude, bit 24 = carry, bit 23 = hidden bit
//   valid_out    result valid, two cycles after the matching valid_in
//   result       packed FP32 {sign, exp[7:0], frac[22:0]}
// -----------------------------------------------------------------------------
module normalize_for_floating_point32 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic        sign,
    input  logic [7:0]  exponent,
    input  logic [24:0] adder_value,
    output logic        valid_out,
    output logic [31:0] result
);

    localparam int STAGES = 2;

    // Result class carried from stage 1 to stage 2.
    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;

    // Valid shifts every cycle: no stall, no backpressure.
    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
    end

    assign valid_out = vld_pipe[STAGES];

    // -------------------------------------------------------------------------
    // Stage 1: classify and normalize
    // -------------------------------------------------------------------------

    // Priority encoder: leading zeros of adder_value[23:0]. An all-zero field
    // only happens in the ZERO or CARRY cases where lzc is not used.
    logic [4:0] lzc;
    logic       lzc_found;

    always_comb begin
        lzc       = 5'd0;
        lzc_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lzc_found && adder_value[i]) begin
                lzc       = 5'(23 - i);
                lzc_found = 1'b1;
            end
        end
    end

    logic [1:0]  n_cls;
    logic        n_sign;
    logic [9:0]  n_exp;   // two's complement, read as signed in stage 2
    logic [23:0] n_mant;
    logic        n_rbit;

    always_comb begin
        n_cls  = CLS_NORM;
        n_sign = sign;
        n_exp  = {2'b00, exponent} - {5'd0, lzc};
        n_mant = adder_value[23:0] << lzc;
        n_rbit = 1'b0;
        if (exponent == 8'hFF) begin
            // An infinite operand dominates whatever the mantissa says.
            n_cls  = CLS_INF;
            n_exp  = '0;
            n_mant = '0;
        end else if (adder_value == 25'd0) begin
            // Exact cancellation always yields +0.
            n_cls  = CLS_ZERO;
            n_sign = 1'b0;
            n_exp  = '0;
            n_mant = '0;
        end else if (adder_value[24]) begin
            // Carry: shift right by one, the dropped bit becomes the round bit.
            n_exp  = {2'b00, exponent} + 10'd1;
            n_mant = adder_value[24:1];
            n_rbit = adder_value[0];
        end
    end

    logic [1:0]  s1_cls;
    logic        s1_sign;
    logic [9:0]  s1_exp;
    logic [23:0] s1_mant;
    logic        s1_rbit;

    // Data registers only load on a valid input; otherwise they hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_cls  <= CLS_NORM;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_rbit <= 1'b0;
        end else if (valid_in) begin
            s1_cls  <= n_cls;
            s1_sign <= n_sign;
            s1_exp  <= n_exp;
            s1_mant <= n_mant;
            s1_rbit <= n_rbit;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: round and pack
    // -------------------------------------------------------------------------

    logic        round_up;
    logic [24:0] mant_sum;
    logic [23:0] r_mant;
    logic [9:0]  r_exp;
    logic [31:0] packed_word;

    // Only a single round bit exists, so rbit=1 is always an exact tie:
    // increment only when that makes the mantissa even.
    assign round_up = s1_rbit & s1_mant[0];
    assign mant_sum = {1'b0, s1_mant} + {24'd0, round_up};

    always_comb begin
        r_mant = mant_sum[23:0];
        r_exp  = s1_exp;
        if (mant_sum[24]) begin
            // Rounding rolled 0xFFFFFF over: renormalize to 1.0 x 2^(e+1).
            r_mant = 24'h800000;
            r_exp  = s1_exp + 10'd1;
        end
    end

    always_comb begin
        packed_word = {s1_sign, r_exp[7:0], r_mant[22:0]};
        if (s1_cls == CLS_INF) begin
            packed_word = {s1_sign, 8'hFF, 23'd0};
        end else if (s1_cls == CLS_ZERO) begin
            packed_word = 32'd0;
        end else if ($signed(r_exp) >= 10'sd255) begin
            packed_word = {s1_sign, 8'hFF, 23'd0};
        end else if ($signed(r_exp) <= 10'sd0) begin
            // No denormals: anything below the normal range flushes to zero.
            packed_word = {s1_sign, 31'd0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            result <= 32'd0;
        else if (vld_pipe[1]) result <= packed_word;
    end

endmodule

// File: tb/tb_normalize_for_floating_point32.sv
// -----------------------------------------------------------------------------
// Bench for normalize_for_floating_point32: directed cases, a streaming burst
// with a bubble, a mid-stream reset and randomized traffic, all scored every
// cycle against a value-level reference model.
// -----------------------------------------------------------------------------
module tb_normalize_for_floating_point32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_in;
    logic        sign;
    logic [7:0]  exponent;
    logic [24:0] adder_value;
    logic        valid_out;
    logic [31:0] result;

    normalize_for_floating_point32 dut (
        .clk         (clk),
        .rstn        (rstn),
        .valid_in    (valid_in),
        .sign        (sign),
        .exponent    (exponent),
        .adder_value (adder_value),
        .valid_out   (valid_out),
        .result      (result)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        v;
        logic [31:0] r;
    } exp_t;

    exp_t        pipe_q[$];
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Value-level model: find the MSB of the magnitude, rescale the exponent
    // accordingly, round the one dropped bit to even, then saturate/flush.
    function automatic logic [31:0] ref_fp(input logic s, input logic [7:0] e,
                                           input logic [24:0] a);
        int     p;
        int     ex;
        longint m;
        longint r;
        if (e == 8'hFF) return {s, 8'hFF, 23'd0};
        if (a == 25'd0) return 32'd0;
        p = 24;
        while (((longint'(a) >> p) & 1) == 0) p--;
        ex = int'(e) + p - 23;
        if (p == 24) begin
            m = longint'(a) >> 1;
            r = longint'(a) & 1;
            if (r == 1 && (m % 2) == 1) m = m + 1;
            if (m == (longint'(1) << 24)) begin
                m  = m / 2;
                ex = ex + 1;
            end
        end else begin
            m = longint'(a) << (23 - p);
        end
        if (ex <= 0)   return {s, 31'd0};
        if (ex >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(ex), 23'(m)};
    endfunction

    task automatic reset_model();
        exp_t idle;
        pipe_q.delete();
        idle.v = 1'b0;
        idle.r = 32'd0;
        pipe_q.push_back(idle);
        held = 32'd0;
    endtask

    // One clock: drive, advance, compare the output against the entry that
    // entered the model one cycle earlier (two edges of latency).
    task automatic step(input logic v, input logic s, input logic [7:0] e,
                        input logic [24:0] a);
        exp_t ent;
        exp_t out;
        valid_in    = v;
        sign        = s;
        exponent    = e;
        adder_value = a;
        ent.v = v;
        ent.r = ref_fp(s, e, a);
        pipe_q.push_back(ent);
        @(posedge clk);
        #1;
        out = pipe_q.pop_front();
        if (out.v) held = out.r;
        chk("valid_out", {31'd0, valid_out}, {31'd0, out.v});
        chk(out.v ? "result" : "result_hold", result, held);
    endtask

    function automatic logic [7:0] rand_exp();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 8'hFF;
        if (k == 1) return 8'($urandom_range(0, 3));
        if (k == 2) return 8'($urandom_range(250, 254));
        return 8'($urandom_range(1, 254));
    endfunction

    function automatic logic [24:0] rand_val();
        int          k;
        logic [24:0] a;
        k = $urandom_range(0, 12);
        a = 25'($urandom);
        if (k == 0) return 25'd0;
        if (k == 1) return a | 25'h1000001;          // carry with round bit set
        return a >> $urandom_range(0, 24);
    endfunction

    initial begin
        rstn        = 1'b0;
        valid_in    = 1'b0;
        sign        = 1'b0;
        exponent    = 8'd0;
        adder_value = 25'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("reset_result", result, 32'd0);
        rstn = 1'b1;
        reset_model();

        // Directed cases
        step(1'b1, 1'b0, 8'd127, 25'h1000000);   // 1.0 + 1.0
        step(1'b1, 1'b0, 8'd127, 25'h0200000);   // 1.5 - 1.25, lzc 2
        step(1'b1, 1'b1, 8'd127, 25'h0000000);   // exact cancellation
        step(1'b1, 1'b0, 8'd127, 25'h1000003);   // tie to even
        step(1'b1, 1'b0, 8'd127, 25'h1FFFFFF);   // round-up mantissa carry
        step(1'b1, 1'b0, 8'd254, 25'h1FFFFFE);   // overflow
        step(1'b1, 1'b1, 8'd1,   25'h0400000);   // underflow
        step(1'b1, 1'b1, 8'hFF,  25'h0812345);   // infinite operand
        step(1'b1, 1'b0, 8'd100, 25'h0000001);   // maximum shift, lzc 23
        step(1'b1, 1'b1, 8'd127, 25'h1000001);   // tie already even, no bump
        step(1'b0, 1'b0, 8'd0,   25'h0);
        step(1'b0, 1'b0, 8'd0,   25'h0);

        // 8 back-to-back, one bubble, 3 more
        for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom), 8'($urandom_range(1, 254)), rand_val());
        step(1'b0, 1'b0, 8'd0, 25'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 8'($urandom_range(1, 254)), rand_val());
        step(1'b0, 1'b0, 8'd0, 25'h0);
        step(1'b0, 1'b0, 8'd0, 25'h0);

        // Reset while two items are in flight (one in stage 1, one at the input)
        step(1'b1, 1'b0, 8'd130, 25'h0F00000);
        valid_in    = 1'b1;
        sign        = 1'b1;
        exponent    = 8'd120;
        adder_value = 25'h1234567;
        #2;
        rstn = 1'b0;
        #1;
        chk("midreset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("midreset_result", result, 32'd0);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("inreset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("inreset_result", result, 32'd0);
        #2;
        rstn = 1'b1;
        reset_model();
        step(1'b0, 1'b0, 8'd0, 25'h0);
        step(1'b0, 1'b0, 8'd0, 25'h0);
        step(1'b1, 1'b0, 8'd127, 25'h1000000);
        step(1'b0, 1'b0, 8'd0, 25'h0);
        step(1'b0, 1'b0, 8'd0, 25'h0);

        // Randomized traffic with random bubbles
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 8), 1'($urandom), rand_exp(), rand_val());
        end
        step(1'b0, 1'b0, 8'd0, 25'h0);
        step(1'b0, 1'b0, 8'd0, 25'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
